// File: rtl/amp_supervisor_if.sv
// amp_supervisor_if: fault inputs and status outputs shared by the amplifier supervisor and its driver
interface amp_supervisor_if #(parameter int NUM_AMP = 2);
  logic [NUM_AMP-1:0] Flt_n;
  logic               clr_latch;
  logic [NUM_AMP-1:0] sht_dwn;
  logic [NUM_AMP-1:0] amp_rdy;
  logic [NUM_AMP-1:0] latched;
  logic [NUM_AMP-1:0] fault_evt;
  modport master (output Flt_n, clr_latch, input sht_dwn, amp_rdy, latched, fault_evt);
  modport slave (input Flt_n, clr_latch, output sht_dwn, amp_rdy, latched, fault_evt);
endinterface

// File: rtl/amp_supervisor.sv
// amp_supervisor: per-channel amplifier power-up hold, fault filtering, retry counting and latch-off
module amp_supervisor #(
  parameter int NUM_AMP     = 2,
  parameter int HOLD_CYCLES = 250000,
  parameter int FLT_FILT    = 4,
  parameter int MAX_RETRY   = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  amp_supervisor_if.slave bus
);
  localparam int HW = $clog2(HOLD_CYCLES + 1);
  localparam int RW = $clog2(MAX_RETRY + 1);
  localparam int FW = $clog2(FLT_FILT + 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
  localparam logic [FW-1:0] FLT_LAST  = FW'(FLT_FILT - 1);
  localparam logic [FW-1:0] FLT_MAX   = FW'(FLT_FILT);
  localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);
  typedef enum logic [1:0] {HOLD, RUN, LATCH} state_t;
  state_t             state     [NUM_AMP];
  state_t             state_nxt [NUM_AMP];
  logic [HW-1:0]      hold_cnt  [NUM_AMP];
  logic [HW-1:0]      hold_nxt  [NUM_AMP];
  logic [RW-1:0]      retry     [NUM_AMP];
  logic [RW-1:0]      retry_nxt [NUM_AMP];
  logic [FW-1:0]      flt_cnt   [NUM_AMP];
  logic [NUM_AMP-1:0] s1, s2, q, evt_nxt;
  // A fault qualifies only on the sample that completes the run of lows, so a held-low input fires once
  always_comb begin
    q       = '0;
    evt_nxt = '0;
    for (int i = 0; i < NUM_AMP; i++) begin
      q[i]         = !s2[i] && (flt_cnt[i] == FLT_LAST);
      state_nxt[i] = state[i];
      hold_nxt[i]  = hold_cnt[i];
      retry_nxt[i] = retry[i];
      case (state[i])
        HOLD: begin
          hold_nxt[i]  = (q[i] || hold_cnt[i] == HOLD_LAST) ? '0 : hold_cnt[i] + 1'b1;
          state_nxt[i] = (!q[i] && hold_cnt[i] == HOLD_LAST) ? RUN : HOLD;
        end
        RUN: if (q[i]) begin
          retry_nxt[i] = (retry[i] == RETRY_MAX) ? retry[i] : retry[i] + 1'b1;
          evt_nxt[i]   = 1'b1;
          hold_nxt[i]  = '0;
          state_nxt[i] = (retry_nxt[i] == RETRY_MAX) ? LATCH : HOLD;
        end
        LATCH: if (bus.clr_latch) begin
          retry_nxt[i] = '0;
          hold_nxt[i]  = '0;
          state_nxt[i] = HOLD;
        end
        default: state_nxt[i] = HOLD;
      endcase
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1            <= '1;
      s2            <= '1;
      bus.sht_dwn   <= '1;
      bus.amp_rdy   <= '0;
      bus.latched   <= '0;
      bus.fault_evt <= '0;
      for (int i = 0; i < NUM_AMP; i++) begin
        state[i]    <= HOLD;
        hold_cnt[i] <= '0;
        retry[i]    <= '0;
        flt_cnt[i]  <= '0;
      end
    end else begin
      s1            <= bus.Flt_n;
      s2            <= s1;
      bus.fault_evt <= evt_nxt;
      for (int i = 0; i < NUM_AMP; i++) begin
        flt_cnt[i]     <= s2[i] ? '0 : (flt_cnt[i] == FLT_MAX) ? flt_cnt[i] : flt_cnt[i] + 1'b1;
        state[i]       <= state_nxt[i];
        hold_cnt[i]    <= hold_nxt[i];
        retry[i]       <= retry_nxt[i];
        bus.sht_dwn[i] <= state_nxt[i] != RUN;
        bus.amp_rdy[i] <= state_nxt[i] == RUN;
        bus.latched[i] <= state_nxt[i] == LATCH;
      end
    end
  end
endmodule
